// File: rtl/riscv_memory_stage.sv
// Memory stage: data-memory req/ack with stall and timeout, store lane
// alignment, load extension and the memory->writeback pipeline register.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_memory_stage #(
    parameter int P_TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_reg_write_m,
    input  logic [1:0]           i_result_src_m,
    input  logic                 i_mem_write_m,
    input  logic [`XLEN-1:0]     i_alu_result_m,
    input  logic [`XLEN-1:0]     i_write_data_m,
    input  logic [4:0]           i_rd_m,
    input  logic [`XLEN-1:0]     i_pc_plus_4m,
    input  logic [`XLEN-1:0]     i_ext_imm_m,
    input  logic [2:0]           i_funct3_m,
    input  logic [3:0]           i_ctrl_mem_byte_sel_m,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [`XLEN-1:0]     o_dmem_addr,
    output logic [`XLEN-1:0]     o_dmem_wdata,
    output logic [3:0]           o_dmem_be,
    input  logic [`XLEN-1:0]     i_dmem_rdata,
    input  logic                 i_dmem_ack,
    output logic                 o_stall_m,
    output logic                 o_misaligned_m,
    output logic                 o_bus_err_m,
    output logic                 o_reg_write_w,
    output logic [1:0]           o_result_src_w,
    output logic [`XLEN-1:0]     o_alu_result_w,
    output logic [`XLEN-1:0]     o_read_data_w,
    output logic [4:0]           o_rd_w,
    output logic [`XLEN-1:0]     o_pc_plus_4w,
    output logic [`XLEN-1:0]     o_ext_imm_w
);
    localparam int W  = `XLEN;
    localparam int CW = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
    // Last WAIT cycle: together with the request cycle in IDLE this
    // gives P_TIMEOUT stalled cycles before the access is abandoned.
    localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 2);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          abort;
    logic          is_load;
    logic          access;
    logic          half;
    logic          word;
    logic          misaligned;
    logic          bubble;
    logic [1:0]    ofs;
    logic [W-1:0]  lane;
    logic [W-1:0]  load_data;

    assign ofs        = i_alu_result_m[1:0];
    assign is_load    = i_result_src_m == 2'b01;
    assign access     = i_mem_write_m | is_load;
    assign half       = i_funct3_m[1:0] == 2'b01;
    assign word       = i_funct3_m[1:0] == 2'b10;
    assign misaligned = access & ((half & ofs[0]) | (word & (ofs != 2'b00)));

    // abort masks the held instruction for the one cycle it drains as a bubble
    assign o_dmem_req = i_rstn &
        ((state == WAIT) | (access & ~misaligned & ~abort));
    assign o_dmem_we      = o_dmem_req & i_mem_write_m;
    assign o_dmem_addr    = {i_alu_result_m[W-1:2], 2'b00};
    assign o_dmem_wdata   = i_write_data_m << {ofs, 3'b000};
    assign o_dmem_be      = o_dmem_req ? 4'(i_ctrl_mem_byte_sel_m << ofs) : 4'b0000;
    assign o_stall_m      = o_dmem_req & ~i_dmem_ack;
    assign o_misaligned_m = i_rstn & misaligned & (state == IDLE) & ~abort;
    assign o_bus_err_m    = abort;

    assign lane = i_dmem_rdata >> {ofs, 3'b000};

    always_comb begin
        load_data = '0;
        case (i_funct3_m)
            3'b000:  load_data = {{(W-8){lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{(W-16){lane[15]}}, lane[15:0]};
            3'b010:  load_data = lane;
            3'b100:  load_data = {{(W-8){1'b0}}, lane[7:0]};
            3'b101:  load_data = {{(W-16){1'b0}}, lane[15:0]};
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            cnt   <= '0;
            abort <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (o_dmem_req && !i_dmem_ack) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (i_dmem_ack) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        abort <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bubble = o_stall_m | o_misaligned_m | o_bus_err_m;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_reg_write_w  <= 1'b0;
            o_result_src_w <= 2'b00;
            o_alu_result_w <= '0;
            o_read_data_w  <= '0;
            o_rd_w         <= 5'd0;
            o_pc_plus_4w   <= '0;
            o_ext_imm_w    <= '0;
        end else begin
            o_reg_write_w  <= i_reg_write_m & ~bubble;
            o_result_src_w <= i_result_src_m;
            o_alu_result_w <= i_alu_result_m;
            o_read_data_w  <= (is_load & o_dmem_req & i_dmem_ack) ? load_data : '0;
            o_rd_w         <= i_rd_m;
            o_pc_plus_4w   <= i_pc_plus_4m;
            o_ext_imm_w    <= i_ext_imm_m;
        end
    end
endmodule

// File: tb/tb_riscv_memory_stage.sv
// Directed bench for the memory stage: vector table for single-cycle
// accesses plus sequences for wait states, timeout and reset.
module tb_riscv_memory_stage;
    localparam int P_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reg_write, mem_write, ack;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
    logic [3:0]  byte_sel;
    logic [4:0]  rd;
    logic [31:0] alu_result, write_data, pc_plus_4, ext_imm, rdata;
    logic        req, we, stall, mis, bus_err;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be;
    logic        rw_w;
    logic [1:0]  rs_w;
    logic [31:0] alu_w, rdata_w, pc_w, imm_w;
    logic [4:0]  rd_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_memory_stage #(.P_TIMEOUT(P_TIMEOUT)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_reg_write_m(reg_write), .i_result_src_m(result_src),
        .i_mem_write_m(mem_write), .i_alu_result_m(alu_result),
        .i_write_data_m(write_data), .i_rd_m(rd),
        .i_pc_plus_4m(pc_plus_4), .i_ext_imm_m(ext_imm),
        .i_funct3_m(funct3), .i_ctrl_mem_byte_sel_m(byte_sel),
        .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr_o),
        .o_dmem_wdata(wdata_o), .o_dmem_be(be),
        .i_dmem_rdata(rdata), .i_dmem_ack(ack),
        .o_stall_m(stall), .o_misaligned_m(mis), .o_bus_err_m(bus_err),
        .o_reg_write_w(rw_w), .o_result_src_w(rs_w),
        .o_alu_result_w(alu_w), .o_read_data_w(rdata_w),
        .o_rd_w(rd_w), .o_pc_plus_4w(pc_w), .o_ext_imm_w(imm_w)
    );

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [3:0]  bs;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        ack;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_stall;
        logic        e_mis;
        logic        e_rw;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [3:0] bs,
                         input logic [31:0] a, input logic [31:0] wd);
        reg_write  = rw;
        mem_write  = mw;
        result_src = rs;
        funct3     = f3;
        byte_sel   = bs;
        alu_result = a;
        write_data = wd;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0);
        ack   = 1'b0;
        rdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // rw mw rs f3 bs addr wd rdata ack | req we addr wdata be stall mis rw rd
        vt.push_back('{0,1,2'b00,3'b010,4'b1111,32'h100,32'hDEADBEEF,32'h0,1,
                       1,1,32'h100,32'hDEADBEEF,4'b1111,0,0,0,32'h0});
        vt.push_back('{0,1,2'b00,3'b000,4'b0001,32'h203,32'h000000AB,32'h0,1,
                       1,1,32'h200,32'hAB000000,4'b1000,0,0,0,32'h0});
        vt.push_back('{0,1,2'b00,3'b001,4'b0011,32'h102,32'h00001234,32'h0,1,
                       1,1,32'h100,32'h12340000,4'b1100,0,0,0,32'h0});
        vt.push_back('{1,0,2'b01,3'b101,4'b0011,32'h102,32'h0,32'hBEEF0000,1,
                       1,0,32'h100,32'h0,4'b1100,0,0,1,32'h0000BEEF});
        vt.push_back('{1,0,2'b01,3'b001,4'b0011,32'h100,32'h0,32'h12348001,1,
                       1,0,32'h100,32'h0,4'b0011,0,0,1,32'hFFFF8001});
        vt.push_back('{1,0,2'b01,3'b000,4'b0001,32'h201,32'h0,32'h00007F00,1,
                       1,0,32'h200,32'h0,4'b0010,0,0,1,32'h0000007F});
        vt.push_back('{1,0,2'b01,3'b100,4'b0001,32'h203,32'h0,32'h80FFFF7F,1,
                       1,0,32'h200,32'h0,4'b1000,0,0,1,32'h00000080});
        vt.push_back('{1,0,2'b01,3'b010,4'b1111,32'h104,32'h0,32'hCAFEF00D,1,
                       1,0,32'h104,32'h0,4'b1111,0,0,1,32'hCAFEF00D});
        vt.push_back('{1,0,2'b01,3'b010,4'b1111,32'h101,32'h0,32'h11111111,1,
                       0,0,32'h100,32'h0,4'b0000,0,1,0,32'h0});
        vt.push_back('{1,0,2'b01,3'b001,4'b0011,32'h103,32'h0,32'h22222222,1,
                       0,0,32'h100,32'h0,4'b0000,0,1,0,32'h0});
        vt.push_back('{0,1,2'b00,3'b010,4'b1111,32'h102,32'h0000ABCD,32'h0,1,
                       0,0,32'h100,32'hABCD0000,4'b0000,0,1,0,32'h0});
        vt.push_back('{1,0,2'b00,3'b000,4'b0000,32'h12345678,32'h0,32'h0,0,
                       0,0,32'h12345678,32'h0,4'b0000,0,0,1,32'h0});
        vt.push_back('{1,0,2'b10,3'b000,4'b0000,32'h40,32'h0,32'hFFFFFFFF,1,
                       0,0,32'h40,32'h0,4'b0000,0,0,1,32'h0});
        vt.push_back('{1,0,2'b01,3'b011,4'b1111,32'h100,32'h0,32'hFFFFFFFF,1,
                       1,0,32'h100,32'h0,4'b1111,0,0,1,32'h0});

        rd        = 5'd7;
        pc_plus_4 = 32'h00001004;
        ext_imm   = 32'h00000055;

        // Reset with a valid load on the inputs: nothing may be requested
        drive(1'b1, 1'b0, 2'b01, 3'b010, 4'b1111, 32'h100, 32'h0);
        ack   = 1'b1;
        rdata = 32'h12345678;
        #12;
        check("rst req", {31'b0, req}, 32'h0);
        check("rst stall", {31'b0, stall}, 32'h0);
        check("rst be", {28'b0, be}, 32'h0);
        check("rst we", {31'b0, we}, 32'h0);
        check("rst err", {31'b0, bus_err}, 32'h0);
        check("rst rw_w", {31'b0, rw_w}, 32'h0);
        check("rst alu_w", alu_w, 32'h0);
        check("rst rdata_w", rdata_w, 32'h0);
        check("rst rd_w", {27'b0, rd_w}, 32'h0);
        check("rst pc_w", pc_w, 32'h0);
        check("rst imm_w", imm_w, 32'h0);
        check("rst rs_w", {30'b0, rs_w}, 32'h0);
        nop();
        tick();
        rstn = 1'b1;
        tick();

        foreach (vt[i]) begin
            drive(vt[i].rw, vt[i].mw, vt[i].rs, vt[i].f3, vt[i].bs,
                  vt[i].addr, vt[i].wd);
            rdata = vt[i].rdata;
            ack   = vt[i].ack;
            #3;
            check($sformatf("v%0d req", i), {31'b0, req}, {31'b0, vt[i].e_req});
            check($sformatf("v%0d we", i), {31'b0, we}, {31'b0, vt[i].e_we});
            check($sformatf("v%0d addr", i), addr_o, vt[i].e_addr);
            check($sformatf("v%0d wdata", i), wdata_o, vt[i].e_wdata);
            check($sformatf("v%0d be", i), {28'b0, be}, {28'b0, vt[i].e_be});
            check($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
            check($sformatf("v%0d mis", i), {31'b0, mis}, {31'b0, vt[i].e_mis});
            check($sformatf("v%0d err", i), {31'b0, bus_err}, 32'h0);
            tick();
            check($sformatf("v%0d rw_w", i), {31'b0, rw_w}, {31'b0, vt[i].e_rw});
            check($sformatf("v%0d rdata_w", i), rdata_w, vt[i].e_rd);
            check($sformatf("v%0d alu_w", i), alu_w, vt[i].addr);
            check($sformatf("v%0d rs_w", i), {30'b0, rs_w}, {30'b0, vt[i].rs});
            nop();
        end
        check("misaligned pulse end", {31'b0, mis}, 32'h0);

        // LB at 0x203, ack after three stalled cycles
        drive(1'b1, 1'b0, 2'b01, 3'b000, 4'b0001, 32'h203, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #3;
            check($sformatf("lb stall c%0d", c), {31'b0, stall}, 32'h1);
            check($sformatf("lb req c%0d", c), {31'b0, req}, 32'h1);
            check($sformatf("lb be c%0d", c), {28'b0, be}, 32'h8);
            tick();
            check($sformatf("lb bubble c%0d", c), {31'b0, rw_w}, 32'h0);
        end
        ack   = 1'b1;
        rdata = 32'h80FFFF7F;
        #3;
        check("lb ack stall", {31'b0, stall}, 32'h0);
        tick();
        check("lb rw_w", {31'b0, rw_w}, 32'h1);
        check("lb rdata_w", rdata_w, 32'hFFFFFF80);
        check("lb rd_w", {27'b0, rd_w}, 32'h7);
        check("lb pc_w", pc_w, 32'h00001004);
        check("lb imm_w", imm_w, 32'h00000055);
        nop();

        // LW with ack withheld: timeout
        drive(1'b1, 1'b0, 2'b01, 3'b010, 4'b1111, 32'h300, 32'h0);
        n = 0;
        for (int c = 0; c < 4 * P_TIMEOUT; c++) begin
            #3;
            if (!stall) break;
            n++;
            tick();
        end
        check("to stall cycles", n, P_TIMEOUT);
        check("to err pulse", {31'b0, bus_err}, 32'h1);
        check("to req dropped", {31'b0, req}, 32'h0);
        tick();
        check("to bubble", {31'b0, rw_w}, 32'h0);
        check("to rdata_w", rdata_w, 32'h0);
        nop();
        #3;
        check("to err end", {31'b0, bus_err}, 32'h0);
        tick();

        // Ack arriving in the last allowed cycle completes normally
        drive(1'b1, 1'b0, 2'b01, 3'b010, 4'b1111, 32'h304, 32'h0);
        n = 0;
        for (int c = 0; c < P_TIMEOUT - 1; c++) begin
            #3;
            if (stall) n++;
            tick();
        end
        check("late stall cycles", n, P_TIMEOUT - 1);
        ack   = 1'b1;
        rdata = 32'h0BADF00D;
        #3;
        check("late stall", {31'b0, stall}, 32'h0);
        check("late req", {31'b0, req}, 32'h1);
        tick();
        check("late err", {31'b0, bus_err}, 32'h0);
        check("late rw_w", {31'b0, rw_w}, 32'h1);
        check("late rdata_w", rdata_w, 32'h0BADF00D);
        nop();
        tick();

        // Reset in the middle of a wait
        drive(1'b1, 1'b0, 2'b01, 3'b010, 4'b1111, 32'h400, 32'h0);
        tick();
        #2;
        check("mid stall", {31'b0, stall}, 32'h1);
        rstn = 1'b0;
        #1;
        check("mid rst req", {31'b0, req}, 32'h0);
        check("mid rst stall", {31'b0, stall}, 32'h0);
        check("mid rst alu_w", alu_w, 32'h0);
        check("mid rst pc_w", pc_w, 32'h0);
        check("mid rst rd_w", {27'b0, rd_w}, 32'h0);
        nop();
        tick();
        rstn = 1'b1;
        ack  = 1'b1;
        #3;
        check("stray ack req", {31'b0, req}, 32'h0);
        check("stray ack stall", {31'b0, stall}, 32'h0);
        tick();
        ack = 1'b0;
        drive(1'b1, 1'b0, 2'b01, 3'b010, 4'b1111, 32'h400, 32'h0);
        #3;
        check("post rst stall", {31'b0, stall}, 32'h1);
        tick();
        ack   = 1'b1;
        rdata = 32'h5A5A5A5A;
        tick();
        check("post rst rdata_w", rdata_w, 32'h5A5A5A5A);
        check("post rst rw_w", {31'b0, rw_w}, 32'h1);
        nop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
